// File: rtl/input_triggered_fsm_if.sv
// Trigger/status bundle for the one-shot sequencer.
// The master drives the trigger and the slave (the sequencer) reports its status.
interface input_triggered_fsm_if;
    logic trigger;
    logic active;
    logic done;

    modport master (output trigger, input active, input done);
    modport slave  (input trigger, output active, output done);
endinterface

// File: rtl/input_triggered_fsm.sv
// One-shot sequencer: a sampled trigger starts a timed ACTIVE window, then a timed DONE pulse.
// All outputs are registered and change together with the state.
module input_triggered_fsm #(
    parameter int unsigned ACTIVE_CYCLES = 2,
    parameter int unsigned DONE_CYCLES   = 1,
    parameter bit          RETRIGGER     = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input_triggered_fsm_if.slave         bus
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StActive = 2'b01,
        StDone   = 2'b10
    } state_e;

    localparam logic [7:0] ActLoad  = 8'(ACTIVE_CYCLES - 1);
    localparam logic [7:0] DoneLoad = 8'(DONE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       active_q, active_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.trigger) begin
                    state_d = StActive;
                    cnt_d   = ActLoad;
                end
            end
            StActive: begin
                if (cnt_q == 8'd0) begin
                    state_d = StDone;
                    cnt_d   = DoneLoad;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDone: begin
                if (cnt_q == 8'd0) begin
                    // Only the final DONE cycle may chain straight into a new run.
                    if (RETRIGGER && bus.trigger) begin
                        state_d = StActive;
                        cnt_d   = ActLoad;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
        active_d = (state_d == StActive);
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign bus.active = active_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_input_triggered_fsm.sv
// Scoreboard bench: two sequencer configurations share stimulus; a countdown model predicts
// {active, done} after every edge and a monitor compares the DUT outputs shortly after each edge.
module tb_input_triggered_fsm;

    logic clk;
    logic reset;

    input_triggered_fsm_if bus0 ();
    input_triggered_fsm_if bus1 ();

    input_triggered_fsm #(
        .ACTIVE_CYCLES (2),
        .DONE_CYCLES   (1),
        .RETRIGGER     (1'b0)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    input_triggered_fsm #(
        .ACTIVE_CYCLES (5),
        .DONE_CYCLES   (3),
        .RETRIGGER     (1'b1)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp0 [$];
    logic [1:0] exp1 [$];

    // Model: rem = cycles left in the current run (ACTIVE then DONE); 0 means idle.
    int rem0 = 0;
    int rem1 = 0;

    function automatic int next_rem(input int rem, input logic r, input logic t,
                                    input int a, input int d, input bit rt);
        if (r) return 0;
        if (rem == 0) return t ? (a + d) : 0;
        if (rem == 1 && rt && t) return a + d;
        return rem - 1;
    endfunction

    function automatic logic [1:0] outs(input int rem, input int d);
        return {rem > d, (rem > 0) && (rem <= d)};
    endfunction

    task automatic model_edge(input logic r, input logic t);
        rem0 = next_rem(rem0, r, t, 2, 1, 1'b0);
        rem1 = next_rem(rem1, r, t, 5, 3, 1'b1);
        exp0.push_back(outs(rem0, 1));
        exp1.push_back(outs(rem1, 3));
    endtask

    task automatic step(input logic r, input logic t);
        @(negedge clk);
        reset        = r;
        bus0.trigger = t;
        bus1.trigger = t;
        @(posedge clk);
        model_edge(r, t);
    endtask

    // Trigger pulse that starts after one rising edge and ends before the next.
    task automatic glitch();
        @(negedge clk);
        reset        = 1'b0;
        bus0.trigger = 1'b0;
        bus1.trigger = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 1'b0);
        #5;
        bus0.trigger = 1'b1;
        bus1.trigger = 1'b1;
        #10;
        bus0.trigger = 1'b0;
        bus1.trigger = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 1'b0);
    endtask

    always @(posedge clk) begin : monitor
        logic [1:0] e;
        #1;
        if (exp0.size() > 0) begin
            e = exp0.pop_front();
            checks++;
            if ({bus0.active, bus0.done} !== e) begin
                failures++;
                $display("FAIL dut0_outputs t=%0t got {active,done}=%b expected=%b",
                         $time, {bus0.active, bus0.done}, e);
            end
        end
        if (exp1.size() > 0) begin
            e = exp1.pop_front();
            checks++;
            if ({bus1.active, bus1.done} !== e) begin
                failures++;
                $display("FAIL dut1_outputs t=%0t got {active,done}=%b expected=%b",
                         $time, {bus1.active, bus1.done}, e);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus0.trigger = 1'b0;
        bus1.trigger = 1'b0;

        // Reset held with trigger high, then the first trigger right after release.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // Pulses between rising edges are never seen.
        glitch();
        glitch();

        // Trigger held continuously: repeating runs, retrigger behaviour on dut1.
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

        // Abort in the second ACTIVE cycle, then a full run.
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // Random trigger traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got pending=%0d/%0d expected=0/0",
                     exp0.size(), exp1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
